tlb_simple: RTL and testbench
=============================

Name: tlb_simple

Overview:
- Small, fully associative translation lookaside buffer (TLB) that maps virtual page numbers (VPN) to physical page numbers (PPN).
- Sits beside the MMU/page-table walker.
- Lookup is combinational (same cycle). Refill writes and invalidations take effect at the next rising clock edge.
- Supports optional ASID tagging and global pages.

Parameters:
- ENTRIES, 4: number of entries; power of two, ≥2.
- VPN_WIDTH, 27: virtual page number width.
- PPN_WIDTH, 27: physical page number width.
- USE_ASID, 1: 1 = ASID participates in matching; 0 = ASID ignored (entries still store it).
- ASID_WIDTH, 8: address-space ID width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  lookup request
- req_vpn  in  VPN_WIDTH  lookup VPN
- req_asid  in  ASID_WIDTH  lookup ASID
- hit  out  1  lookup hit
- hit_index  out  clog2(ENTRIES)  matching entry index
- hit_ppn  out  PPN_WIDTH  translated PPN
- hit_dirty  out  1  entry D bit
- hit_accessed  out  1  entry A bit
- hit_perm  out  3  entry permissions {R,W,X} as [2:0]
- hit_global  out  1  entry G bit
- inval_all  in  1  flush all entries
- inval_vpn_valid  in  1  invalidate by VPN/ASID
- inval_vpn  in  VPN_WIDTH  VPN to invalidate
- inval_asid  in  ASID_WIDTH  ASID to invalidate
- write_valid  in  1  refill write
- write_idx_valid  in  1  1 = use write_idx; 0 = use repl_index
- write_idx  in  clog2(ENTRIES)  explicit target entry
- write_vpn / write_ppn  in  VPN_WIDTH / PPN_WIDTH  refill tags/data
- write_dirty, write_accessed, write_global  in  1 each  refill flag bits
- write_perm  in  3  refill permissions
- write_asid  in  ASID_WIDTH  refill ASID
- repl_index  out  clog2(ENTRIES)  victim chosen for the next write

Behaviour:
- Entry state: valid, vpn, ppn, asid, dirty, accessed, perm, global.
- Reset (asynchronous, rst_n=0): all valid bits and all stored fields cleared; round-robin pointer = 0.
  - Consequence: hit=0, all hit_* = 0, repl_index=0.
- Match condition for entry i: valid & vpn==req_vpn & (!USE_ASID | global | asid==req_asid).
- Lookup is purely combinational from req_valid/req_vpn/req_asid and the current entry state.
  - hit = req_valid & any match.
  - On a miss, or when req_valid=0, all hit_* outputs are 0.
- Multiple matches: lowest matching index wins.
- Lookups do not modify state, unless the optional feature below is compiled in.
- Write (write_valid=1) at the clock edge:
  - Target is write_idx if write_idx_valid=1.
  - Otherwise, an existing valid entry already matching write_vpn/write_asid (same match rule, global ignored) is overwritten in place.
  - Otherwise the target is repl_index.
  - The target gets valid=1 and all write_* fields.
- repl_index: lowest-indexed invalid entry if any exist; otherwise the round-robin pointer.
  - The pointer increments (wrapping from ENTRIES-1 to 0) only on a write that used repl_index while all entries were valid.
- inval_vpn_valid at the clock edge clears valid on every entry with vpn==inval_vpn and (!USE_ASID | asid==inval_asid).
  - Global entries are cleared only on an exact ASID match.
- inval_all at the clock edge clears every valid bit; the pointer is unchanged.
- Same-cycle priority:
  - inval_all overrides a write and inval_vpn (the entry ends invalid).
  - When a write and inval_vpn coincide, the invalidation is applied first and the write second, so the written entry ends valid.
- A lookup in the same cycle as a write or invalidation sees the pre-edge state.
- Reset asserted mid-operation discards all state immediately.

Optional Feature:
- Macro: TLB_ACCESSED_UPDATE_EN.
- Defined: on a clock edge where hit=1, the hit entry's accessed bit is set to 1. This update has lower priority than a write or invalidation targeting the same entry in that cycle.
- Undefined: lookups never modify state; the accessed bit changes only via writes.

Decomposition:
- Package tlb_pkg: an entry struct typedef (valid, vpn, ppn, asid, dirty, accessed, perm, global) parameterised via package localparams, plus PERM_R/W/X bit-position constants.
- One natural sub-module, tlb_match_enc: the per-entry match vector plus a priority encoder yielding hit and index. It is reused for lookup, write-path dedup and first-invalid search.

Test Plan:
- Reset, no writes: req_valid=1, vpn 27'h12345 → hit=0, hit_ppn=0, repl_index=0.
- Write vpn 27'h12345, ppn 27'h00ABC, perm 3'b111, asid 8'h01, write_idx_valid=0; then look up the same vpn/asid → hit=1, hit_index=0, hit_ppn=27'h00ABC, hit_perm=3'b111; repl_index=1.
- After that write, inval_vpn_valid with vpn 27'h12345, asid 8'h01 for one cycle → next cycle hit=0 for the same request.
- ASID check: entry asid 8'h01 with global=0, request asid 8'h02 → hit=0. Same with global=1 → hit=1.
- Fill all 4 entries, then write 2 more via repl → entries 0 and 1 replaced; repl_index sequence 0,1,2,3,0,1,2.
- Same cycle inval_all + write_valid → all entries invalid. Separately, a duplicate-VPN write with new ppn 27'h1 overwrites in place → hit_index unchanged, hit_ppn=27'h1.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared types and constants for the tlb_simple slice: stored entry layout and permission bit positions.
package tlb_pkg;

   localparam int VPN_W  = 27;
   localparam int PPN_W  = 27;
   localparam int ASID_W = 8;

   localparam int PERM_R = 2;
   localparam int PERM_W = 1;
   localparam int PERM_X = 0;

   typedef struct packed {
      logic              valid;
      logic [VPN_W-1:0]  vpn;
      logic [PPN_W-1:0]  ppn;
      logic [ASID_W-1:0] asid;
      logic              dirty;
      logic              accessed;
      logic [2:0]        perm;
      logic              is_global;
   } tlb_entry_t;

endpackage

// File: rtl/tlb_match_enc.sv
// Per-entry tag match vector followed by a lowest-index-wins priority encoder.
// With cmp_tags=0 it degenerates to a "first set bit of cand" search.
module tlb_match_enc
   import tlb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]             cand,
   input  logic [N-1:0][VPN_W-1:0]  vpns,
   input  logic [N-1:0][ASID_W-1:0] asids,
   input  logic [N-1:0]             globals,
   input  logic                     cmp_tags,
   input  logic                     cmp_asid,
   input  logic                     global_ok,
   input  logic [VPN_W-1:0]         vpn,
   input  logic [ASID_W-1:0]        asid,
   output logic                     any,
   output logic [IW-1:0]            index
);

   logic [N-1:0] match;

   for (genvar gi = 0; gi < N; gi++) begin : g_match
      assign match[gi] = cand[gi] & (!cmp_tags | ((vpns[gi] == vpn) &
                         (!cmp_asid | (global_ok & globals[gi]) | (asids[gi] == asid))));
   end

   always_comb begin
      any   = |match;
      index = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (match[i]) index = IW'(i);
      end
   end

endmodule

// File: rtl/tlb_simple.sv
// Fully associative TLB: combinational lookup, clocked refill/invalidate, round-robin victim pointer.
// Optional macro TLB_ACCESSED_UPDATE_EN: a hit sets the entry's accessed bit at the next edge.
module tlb_simple
   import tlb_pkg::*;
#(
   parameter int ENTRIES    = 4,
   parameter int VPN_WIDTH  = VPN_W,
   parameter int PPN_WIDTH  = PPN_W,
   parameter int USE_ASID   = 1,
   parameter int ASID_WIDTH = ASID_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid,
   input  logic [VPN_WIDTH-1:0]         req_vpn,
   input  logic [ASID_WIDTH-1:0]        req_asid,
   output logic                         hit,
   output logic [$clog2(ENTRIES)-1:0]   hit_index,
   output logic [PPN_WIDTH-1:0]         hit_ppn,
   output logic                         hit_dirty,
   output logic                         hit_accessed,
   output logic [2:0]                   hit_perm,
   output logic                         hit_global,
   input  logic                         inval_all,
   input  logic                         inval_vpn_valid,
   input  logic [VPN_WIDTH-1:0]         inval_vpn,
   input  logic [ASID_WIDTH-1:0]        inval_asid,
   input  logic                         write_valid,
   input  logic                         write_idx_valid,
   input  logic [$clog2(ENTRIES)-1:0]   write_idx,
   input  logic [VPN_WIDTH-1:0]         write_vpn,
   input  logic [PPN_WIDTH-1:0]         write_ppn,
   input  logic                         write_dirty,
   input  logic                         write_accessed,
   input  logic                         write_global,
   input  logic [2:0]                   write_perm,
   input  logic [ASID_WIDTH-1:0]        write_asid,
   output logic [$clog2(ENTRIES)-1:0]   repl_index
);

   localparam int IW = $clog2(ENTRIES);

   // Storage uses the package entry layout; widths here must agree with tlb_pkg.
   tlb_entry_t ent_reg [ENTRIES];
   logic [IW-1:0] rr_ptr_reg;

   logic [ENTRIES-1:0]             valid_vec, glob_vec, inval_vec;
   logic [ENTRIES-1:0][VPN_W-1:0]  vpn_vec;
   logic [ENTRIES-1:0][ASID_W-1:0] asid_vec;
   logic                           cmp_asid;

   assign cmp_asid = (USE_ASID != 0);

   for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_flat
      assign valid_vec[gi] = ent_reg[gi].valid;
      assign glob_vec[gi]  = ent_reg[gi].is_global;
      assign vpn_vec[gi]   = ent_reg[gi].vpn;
      assign asid_vec[gi]  = ent_reg[gi].asid;
      assign inval_vec[gi] = inval_vpn_valid && (ent_reg[gi].vpn == inval_vpn) &&
                             (!cmp_asid || (ent_reg[gi].asid == inval_asid));
   end

   logic          look_any, dup_any, free_any;
   logic [IW-1:0] look_idx, dup_idx, free_idx;

   tlb_match_enc #(.N(ENTRIES)) u_lookup (
      .cand(valid_vec), .vpns(vpn_vec), .asids(asid_vec), .globals(glob_vec),
      .cmp_tags(1'b1), .cmp_asid(cmp_asid), .global_ok(1'b1),
      .vpn(req_vpn), .asid(req_asid), .any(look_any), .index(look_idx)
   );

   // Refill dedup ignores the global bit so a re-walk of the same page lands in place.
   tlb_match_enc #(.N(ENTRIES)) u_dedup (
      .cand(valid_vec), .vpns(vpn_vec), .asids(asid_vec), .globals(glob_vec),
      .cmp_tags(1'b1), .cmp_asid(cmp_asid), .global_ok(1'b0),
      .vpn(write_vpn), .asid(write_asid), .any(dup_any), .index(dup_idx)
   );

   tlb_match_enc #(.N(ENTRIES)) u_free (
      .cand(~valid_vec), .vpns(vpn_vec), .asids(asid_vec), .globals(glob_vec),
      .cmp_tags(1'b0), .cmp_asid(1'b0), .global_ok(1'b0),
      .vpn(write_vpn), .asid(write_asid), .any(free_any), .index(free_idx)
   );

   tlb_entry_t hit_entry, new_entry;
   logic [IW-1:0] write_tgt;
   logic          use_rr;

   assign repl_index = free_any ? free_idx : rr_ptr_reg;
   assign hit        = req_valid & look_any;
   assign hit_entry  = ent_reg[look_idx];
   assign hit_index  = hit ? look_idx : '0;
   assign hit_ppn    = hit ? hit_entry.ppn : '0;
   assign hit_dirty  = hit & hit_entry.dirty;
   assign hit_accessed = hit & hit_entry.accessed;
   assign hit_perm   = hit ? hit_entry.perm : 3'b000;
   assign hit_global = hit & hit_entry.is_global;

   assign write_tgt = write_idx_valid ? write_idx : (dup_any ? dup_idx : repl_index);
   assign use_rr    = write_valid & !write_idx_valid & !dup_any & !free_any;

   always_comb begin
      new_entry              = '0;
      new_entry.valid        = 1'b1;
      new_entry.vpn          = write_vpn;
      new_entry.ppn          = write_ppn;
      new_entry.asid         = write_asid;
      new_entry.dirty        = write_dirty;
      new_entry.accessed     = write_accessed;
      new_entry.perm[PERM_R] = write_perm[PERM_R];
      new_entry.perm[PERM_W] = write_perm[PERM_W];
      new_entry.perm[PERM_X] = write_perm[PERM_X];
      new_entry.is_global    = write_global;
   end

   // Later non-blocking assignments win: invalidate, then accessed update, then write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) ent_reg[i] <= '0;
         rr_ptr_reg <= '0;
      end else if (inval_all) begin
         for (int i = 0; i < ENTRIES; i++) ent_reg[i].valid <= 1'b0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (inval_vec[i]) ent_reg[i].valid <= 1'b0;
         end
`ifdef TLB_ACCESSED_UPDATE_EN
         if (hit && !inval_vec[look_idx])
            ent_reg[look_idx].accessed <= 1'b1;
`endif
         if (write_valid) ent_reg[write_tgt] <= new_entry;
         if (use_rr)      rr_ptr_reg <= rr_ptr_reg + IW'(1);
      end
   end

endmodule

// File: tb/tb_tlb_simple.sv
// Self-checking bench for tlb_simple: directed vector table, hand sequences, then random ops vs a reference model.
module tb_tlb_simple;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic [26:0] req_vpn;
   logic [7:0]  req_asid;
   logic        hit;
   logic [1:0]  hit_index;
   logic [26:0] hit_ppn;
   logic        hit_dirty, hit_accessed, hit_global;
   logic [2:0]  hit_perm;
   logic        inval_all, inval_vpn_valid;
   logic [26:0] inval_vpn;
   logic [7:0]  inval_asid;
   logic        write_valid, write_idx_valid;
   logic [1:0]  write_idx;
   logic [26:0] write_vpn, write_ppn;
   logic        write_dirty, write_accessed, write_global;
   logic [2:0]  write_perm;
   logic [7:0]  write_asid;
   logic [1:0]  repl_index;

   always #5 clk = ~clk;

   tlb_simple dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_vpn(req_vpn), .req_asid(req_asid),
      .hit(hit), .hit_index(hit_index), .hit_ppn(hit_ppn), .hit_dirty(hit_dirty),
      .hit_accessed(hit_accessed), .hit_perm(hit_perm), .hit_global(hit_global),
      .inval_all(inval_all), .inval_vpn_valid(inval_vpn_valid), .inval_vpn(inval_vpn),
      .inval_asid(inval_asid), .write_valid(write_valid), .write_idx_valid(write_idx_valid),
      .write_idx(write_idx), .write_vpn(write_vpn), .write_ppn(write_ppn),
      .write_dirty(write_dirty), .write_accessed(write_accessed), .write_global(write_global),
      .write_perm(write_perm), .write_asid(write_asid), .repl_index(repl_index)
   );

   // Reference model: a plain list of entries plus the victim pointer.
   typedef struct {
      bit          v;
      logic [26:0] vpn, ppn;
      logic [7:0]  asid;
      bit          d, a, g;
      logic [2:0]  perm;
   } ment_t;

   ment_t m[N];
   int    m_ptr;
   int    checks = 0;
   int    errors = 0;

   task automatic chk(string tag, string field, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got %0h, expected %0h", tag, field, act, exp);
      end
   endtask

   function automatic int m_find(logic [26:0] vpn, logic [7:0] asid, bit allow_g);
      for (int i = 0; i < N; i++)
         if (m[i].v && m[i].vpn == vpn && (m[i].asid == asid || (allow_g && m[i].g))) return i;
      return -1;
   endfunction

   function automatic int m_repl();
      for (int i = 0; i < N; i++) if (!m[i].v) return i;
      return m_ptr;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < N; i++) m[i] = '{0, 0, 0, 0, 0, 0, 0, 0};
      m_ptr = 0;
   endtask

   task automatic idle();
      req_valid = 0; req_vpn = 0; req_asid = 0;
      inval_all = 0; inval_vpn_valid = 0; inval_vpn = 0; inval_asid = 0;
      write_valid = 0; write_idx_valid = 0; write_idx = 0; write_vpn = 0; write_ppn = 0;
      write_dirty = 0; write_accessed = 0; write_global = 0; write_perm = 0; write_asid = 0;
   endtask

   task automatic check_model(string tag);
      int k;
      k = req_valid ? m_find(req_vpn, req_asid, 1) : -1;
      chk(tag, "hit", hit, k >= 0);
      if (k >= 0) begin
         chk(tag, "hit_index", hit_index, k);
         chk(tag, "hit_ppn", hit_ppn, m[k].ppn);
         chk(tag, "hit_flags", {hit_dirty, hit_accessed, hit_global, hit_perm},
             {m[k].d, m[k].a, m[k].g, m[k].perm});
      end else begin
         chk(tag, "miss_zero", {hit_index, hit_ppn, hit_dirty, hit_accessed, hit_global, hit_perm}, 0);
      end
      chk(tag, "repl_index", repl_index, m_repl());
   endtask

   // Apply the pending inputs to the model, then take the clock edge.
   task automatic finish_cycle();
      int  k, tgt;
      bit  rr;
      k   = req_valid ? m_find(req_vpn, req_asid, 1) : -1;
      rr  = 0;
      tgt = write_idx_valid ? int'(write_idx) : m_find(write_vpn, write_asid, 0);
      if (tgt < 0) begin
         tgt = m_repl();
         rr  = 1;
         for (int i = 0; i < N; i++) if (!m[i].v) rr = 0;
      end
      if (inval_all) begin
         for (int i = 0; i < N; i++) m[i].v = 0;
      end else begin
         if (inval_vpn_valid)
            for (int i = 0; i < N; i++)
               if (m[i].vpn == inval_vpn && m[i].asid == inval_asid) m[i].v = 0;
`ifdef TLB_ACCESSED_UPDATE_EN
         if (k >= 0 && m[k].v) m[k].a = 1;
`endif
         if (write_valid) begin
            m[tgt] = '{1, write_vpn, write_ppn, write_asid, write_dirty, write_accessed,
                       write_global, write_perm};
            if (rr) m_ptr = (m_ptr + 1) % N;
         end
      end
      @(posedge clk);
      #1;
      idle();
   endtask

   typedef struct {
      bit          w;
      logic [26:0] wvpn, wppn;
      bit          wg;
      logic [2:0]  wperm;
      bit          ia, iv;
      logic [26:0] ivpn, rvpn;
      logic [7:0]  rasid;
      bit          ehit;
      logic [1:0]  eidx;
      logic [26:0] eppn;
      logic [2:0]  eperm;
      logic [1:0]  erepl;
   } vec_t;

   vec_t tbl[$];

   initial begin
      // Expected lookup fields describe the state before that row's clock edge.
      tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 27'h12345, 1, 0, 0, 0, 0, 0});
      tbl.push_back('{1, 27'h12345, 27'h00ABC, 0, 3'b111, 0, 0, 0, 27'h12345, 1, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 27'h12345, 27'h12345, 1, 1, 0, 27'h00ABC, 3'b111, 1});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 27'h12345, 1, 0, 0, 0, 0, 0});
      tbl.push_back('{1, 27'h12345, 27'h5, 0, 3'b011, 0, 0, 0, 27'h12345, 1, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 27'h12345, 2, 0, 0, 0, 0, 1});
      tbl.push_back('{1, 27'h12345, 27'h6, 1, 3'b101, 0, 0, 0, 27'h12345, 2, 0, 0, 0, 0, 1});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 27'h12345, 2, 1, 0, 27'h6, 3'b101, 1});
      tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 27'h12345, 1, 1, 0, 27'h6, 3'b101, 1});
      tbl.push_back('{1, 27'h100, 27'h100, 0, 3'b011, 0, 0, 0, 27'h12345, 1, 0, 0, 0, 0, 0});
      tbl.push_back('{1, 27'h101, 27'h101, 0, 3'b011, 0, 0, 0, 27'h100, 1, 1, 0, 27'h100, 3'b011, 1});
      tbl.push_back('{1, 27'h102, 27'h102, 0, 3'b011, 0, 0, 0, 27'h101, 1, 1, 1, 27'h101, 3'b011, 2});
      tbl.push_back('{1, 27'h103, 27'h103, 0, 3'b011, 0, 0, 0, 27'h102, 1, 1, 2, 27'h102, 3'b011, 3});
      tbl.push_back('{1, 27'h104, 27'h104, 0, 3'b011, 0, 0, 0, 27'h103, 1, 1, 3, 27'h103, 3'b011, 0});
      tbl.push_back('{1, 27'h105, 27'h105, 0, 3'b011, 0, 0, 0, 27'h104, 1, 1, 0, 27'h104, 3'b011, 1});
      tbl.push_back('{1, 27'h102, 27'h1, 0, 3'b011, 0, 0, 0, 27'h105, 1, 1, 1, 27'h105, 3'b011, 2});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 27'h102, 1, 1, 2, 27'h1, 3'b011, 2});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 27'h100, 1, 0, 0, 0, 0, 2});

      idle();
      m_reset();
      rst_n = 0;
      #12;
      rst_n = 1;
      @(posedge clk);
      #1;

      for (int r = 0; r < tbl.size(); r++) begin
         string tag;
         tag = $sformatf("vec%0d", r);
         req_valid = 1; req_vpn = tbl[r].rvpn; req_asid = tbl[r].rasid;
         write_valid = tbl[r].w; write_vpn = tbl[r].wvpn; write_ppn = tbl[r].wppn;
         write_global = tbl[r].wg; write_perm = tbl[r].wperm; write_asid = 8'h01;
         inval_all = tbl[r].ia; inval_vpn_valid = tbl[r].iv; inval_vpn = tbl[r].ivpn;
         inval_asid = 8'h01;
         #4;
         chk(tag, "hit", hit, tbl[r].ehit);
         chk(tag, "hit_index", hit_index, tbl[r].eidx);
         chk(tag, "hit_ppn", hit_ppn, tbl[r].eppn);
         chk(tag, "hit_perm", hit_perm, tbl[r].eperm);
         chk(tag, "repl_index", repl_index, tbl[r].erepl);
         check_model(tag);
         $display("vec%0d: w=%0d ia=%0d iv=%0d lookup %0h -> hit=%0d idx=%0d ppn=%0h repl=%0d",
                  r, tbl[r].w, tbl[r].ia, tbl[r].iv, tbl[r].rvpn, hit, hit_index, hit_ppn, repl_index);
         finish_cycle();
      end

      // Write and VPN invalidation hitting the same entry in one cycle: the write survives.
      write_valid = 1; write_idx_valid = 1; write_idx = 3; write_vpn = 27'h103;
      write_ppn = 27'h77; write_asid = 8'h01; write_perm = 3'b100;
      inval_vpn_valid = 1; inval_vpn = 27'h103; inval_asid = 8'h01;
      #4;
      check_model("seq_wr_inv_pre");
      finish_cycle();
      req_valid = 1; req_vpn = 27'h103; req_asid = 8'h01;
      #4;
      chk("seq_wr_inv", "hit", hit, 1);
      chk("seq_wr_inv", "hit_index", hit_index, 3);
      chk("seq_wr_inv", "hit_ppn", hit_ppn, 27'h77);
      $display("seq_wr_inv: hit=%0d idx=%0d ppn=%0h", hit, hit_index, hit_ppn);
      finish_cycle();

      // Flush-all wins over a simultaneous refill.
      inval_all = 1; write_valid = 1; write_vpn = 27'h200; write_ppn = 27'h200; write_asid = 8'h01;
      #4;
      finish_cycle();
      req_valid = 1; req_vpn = 27'h200; req_asid = 8'h01;
      #4;
      chk("seq_flush", "hit", hit, 0);
      chk("seq_flush", "repl_index", repl_index, 0);
      $display("seq_flush: hit=%0d repl=%0d", hit, repl_index);
      finish_cycle();

      for (int t = 0; t < 400; t++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_vpn = 27'($urandom_range(0, 5)); req_asid = 8'($urandom_range(1, 2));
         write_valid = ($urandom_range(0, 2) == 0);
         write_idx_valid = ($urandom_range(0, 3) == 0); write_idx = 2'($urandom_range(0, 3));
         write_vpn = 27'($urandom_range(0, 5)); write_ppn = 27'($urandom);
         write_asid = 8'($urandom_range(1, 2)); write_global = ($urandom_range(0, 3) == 0);
         write_dirty = 1'($urandom); write_accessed = 1'($urandom); write_perm = 3'($urandom);
         inval_vpn_valid = ($urandom_range(0, 5) == 0);
         inval_vpn = 27'($urandom_range(0, 5)); inval_asid = 8'($urandom_range(1, 2));
         inval_all = ($urandom_range(0, 39) == 0);
         #4;
         check_model($sformatf("rnd%0d", t));
         $display("rnd%0d: req=%0d vpn=%0d asid=%0d w=%0d iv=%0d ia=%0d -> hit=%0d idx=%0d repl=%0d",
                  t, req_valid, req_vpn, req_asid, write_valid, inval_vpn_valid, inval_all,
                  hit, hit_index, repl_index);
         finish_cycle();
      end

      // Reset asserted between edges discards a live entry immediately.
      write_valid = 1; write_vpn = 27'h7; write_ppn = 27'h9; write_asid = 8'h01;
      #4;
      finish_cycle();
      req_valid = 1; req_vpn = 27'h7; req_asid = 8'h01;
      #2;
      chk("async_rst", "hit_before", hit, 1);
      rst_n = 0;
      m_reset();
      #1;
      chk("async_rst", "hit", hit, 0);
      chk("async_rst", "hit_ppn", hit_ppn, 0);
      chk("async_rst", "repl_index", repl_index, 0);
      $display("async_rst: hit=%0d ppn=%0h repl=%0d", hit, hit_ppn, repl_index);
      #3;
      rst_n = 1;
      @(posedge clk);
      #1;
      req_valid = 1; req_vpn = 27'h7; req_asid = 8'h01;
      #4;
      check_model("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
